// File: rtl/ring_noc_pkg.sv
// Shared ring network-interface definitions: command codes, flit control
// encodings, uploader state encodings and default head-flit field positions.
package ring_noc_pkg;

    // Default geometry of the uploader and the head-flit layout.
    localparam int FLIT_W_DEF    = 16;
    localparam int MAX_FLITS_DEF = 11;
    localparam int NUM_NODES_DEF = 4;
    localparam int CMD_LSB_DEF   = 5;
    localparam int DEST_LSB_DEF  = 14;
    localparam int CMD_W         = 5;

    // Ring request commands carried in the head flit.
    localparam logic [CMD_W-1:0] CMD_RDREQ    = 5'b00000;
    localparam logic [CMD_W-1:0] CMD_WBREQ    = 5'b00010;
    localparam logic [CMD_W-1:0] CMD_INVREQ   = 5'b00100;
    localparam logic [CMD_W-1:0] CMD_SCINVREQ = 5'b00110;
    localparam logic [CMD_W-1:0] CMD_FLUSHREQ = 5'b01000;

    // Uploader FSM encodings (visible on fsm_state_out).
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SEND = 2'b01,
        ST_DONE = 2'b10
    } upl_state_e;

    // out_ctrl encodings.
    typedef enum logic [1:0] {
        CTRL_NONE = 2'b00,
        CTRL_HEAD = 2'b01,
        CTRL_BODY = 2'b10,
        CTRL_TAIL = 2'b11
    } flit_ctrl_e;

    // Invalidation-class commands are multicast to every sharer.
    function automatic logic is_multicast_cmd(input logic [CMD_W-1:0] cmd);
        return (cmd == CMD_INVREQ) || (cmd == CMD_SCINVREQ);
    endfunction

endpackage

// File: rtl/flit_upload_serializer_if.sv
// Message-in / flit-out bundle of the uploader. The master side offers
// messages and drains flits; the slave side is the uploader itself.
interface flit_upload_serializer_if
    import ring_noc_pkg::*;
#(
    parameter int FLIT_W    = FLIT_W_DEF,
    parameter int MAX_FLITS = MAX_FLITS_DEF,
    parameter int NUM_NODES = NUM_NODES_DEF
);
    localparam int CNT_W = $clog2(MAX_FLITS + 1);

    logic                        msg_valid;
    logic                        msg_ready;
    logic [FLIT_W*MAX_FLITS-1:0] msg_flits;
    logic [CNT_W-1:0]            msg_len;
    logic [NUM_NODES-1:0]        msg_inv_vec;
    logic [FLIT_W-1:0]           out_flit;
    logic [1:0]                  out_ctrl;
    logic                        out_valid;
    logic                        out_rdy;
    logic                        msg_done;

    modport master (
        output msg_valid, msg_flits, msg_len, msg_inv_vec, out_rdy,
        input  msg_ready, out_flit, out_ctrl, out_valid, msg_done
    );

    modport slave (
        input  msg_valid, msg_flits, msg_len, msg_inv_vec, out_rdy,
        output msg_ready, out_flit, out_ctrl, out_valid, msg_done
    );

endinterface

// File: rtl/flit_upload_serializer_lsb_enc.sv
// Lowest-set-bit encoder used to pick the next multicast destination.
module lowest_set_bit_enc #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  mask,
    output logic [IW-1:0] idx,
    output logic          any
);

    // Scan from the top so the lowest set bit is the last one to win.
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = mask[i] ? IW'(i) : idx;
        end
        any = |mask;
    end

endmodule

// File: rtl/flit_upload_serializer.sv
// Parallel message to serial flit uploader. Unicast messages are streamed
// once; invalidation-class messages are streamed once per sharer with the
// head destination rewritten. All outputs are registered: next-cycle values
// are computed from the next state so a new copy starts with no bubble.
module flit_upload_serializer
    import ring_noc_pkg::*;
#(
    parameter int FLIT_W    = FLIT_W_DEF,
    parameter int MAX_FLITS = MAX_FLITS_DEF,
    parameter int NUM_NODES = NUM_NODES_DEF,
    parameter int CMD_LSB   = CMD_LSB_DEF,
    parameter int DEST_LSB  = DEST_LSB_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    flit_upload_serializer_if.slave  bus,
    output logic [1:0]               fsm_state_out
);

    localparam int CNT_W = $clog2(MAX_FLITS + 1);
    localparam int DW    = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
    localparam int MSG_W = FLIT_W * MAX_FLITS;

    // Registered state
    upl_state_e           state_r;
    logic [MSG_W-1:0]     flits_r;
    logic [CNT_W-1:0]     len_r;
    logic [CNT_W-1:0]     cnt_r;
    logic                 mcast_r;
    logic [NUM_NODES-1:0] mask_r;
    logic [DW-1:0]        dest_r;
    logic [FLIT_W-1:0]    out_flit_r;
    logic [1:0]           out_ctrl_r;
    logic                 out_valid_r;
    logic                 msg_ready_r;
    logic                 msg_done_r;

    // Next-state values
    upl_state_e           nxt_state_s;
    logic [MSG_W-1:0]     nxt_flits_s;
    logic [CNT_W-1:0]     nxt_len_s;
    logic [CNT_W-1:0]     nxt_cnt_s;
    logic                 nxt_mcast_s;
    logic [NUM_NODES-1:0] nxt_mask_s;
    logic [DW-1:0]        nxt_dest_s;
    logic                 nxt_any_s;
    logic                 nxt_valid_s;
    logic [FLIT_W-1:0]    sel_flit_s;
    logic [FLIT_W-1:0]    dest_flit_s;
    logic [FLIT_W-1:0]    nxt_out_flit_s;
    logic [1:0]           nxt_ctrl_s;

    // Helpers
    logic [CNT_W-1:0]     clamp_len_s;
    logic                 mcast_in_s;
    logic                 xfer_s;
    logic                 last_s;
    logic [NUM_NODES-1:0] mask_clr_s;

    assign mcast_in_s = is_multicast_cmd(bus.msg_flits[CMD_LSB +: CMD_W]);
    assign xfer_s     = out_valid_r && bus.out_rdy;
    assign last_s     = (cnt_r == (len_r - CNT_W'(1)));
    assign mask_clr_s = mask_r & ~(NUM_NODES'(1) << dest_r);

    // Length normalisation: zero means one flit, oversize is clamped.
    always_comb begin
        if (bus.msg_len == '0) begin
            clamp_len_s = CNT_W'(1);
        end else if (bus.msg_len > CNT_W'(MAX_FLITS)) begin
            clamp_len_s = CNT_W'(MAX_FLITS);
        end else begin
            clamp_len_s = bus.msg_len;
        end
    end

    // Next-state logic for the accept / stream / finish sequence.
    always_comb begin
        nxt_state_s = state_r;
        nxt_flits_s = flits_r;
        nxt_len_s   = len_r;
        nxt_cnt_s   = cnt_r;
        nxt_mcast_s = mcast_r;
        nxt_mask_s  = mask_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.msg_valid) begin
                    nxt_flits_s = bus.msg_flits;
                    nxt_len_s   = clamp_len_s;
                    nxt_cnt_s   = '0;
                    nxt_mcast_s = mcast_in_s;
                    nxt_mask_s  = mcast_in_s ? bus.msg_inv_vec : '0;
                    if (mcast_in_s && (bus.msg_inv_vec == '0)) begin
                        nxt_state_s = ST_DONE;
                    end else begin
                        nxt_state_s = ST_SEND;
                    end
                end else begin
                    nxt_state_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (xfer_s) begin
                    if (!last_s) begin
                        nxt_cnt_s = cnt_r + CNT_W'(1);
                    end else if (!mcast_r) begin
                        nxt_state_s = ST_DONE;
                    end else begin
                        // Copy finished: retire this sharer and restart at the head.
                        nxt_mask_s = mask_clr_s;
                        nxt_cnt_s  = '0;
                        if (mask_clr_s == '0) begin
                            nxt_state_s = ST_DONE;
                        end else begin
                            nxt_state_s = ST_SEND;
                        end
                    end
                end else begin
                    nxt_state_s = ST_SEND;
                end
            end
            ST_DONE: begin
                nxt_state_s = ST_IDLE;
            end
            default: begin
                nxt_state_s = ST_IDLE;
            end
        endcase
    end

    // Destination of the copy that the next-cycle head flit belongs to.
    lowest_set_bit_enc #(
        .N  (NUM_NODES),
        .IW (DW)
    ) u_lsb_enc (
        .mask (nxt_mask_s),
        .idx  (nxt_dest_s),
        .any  (nxt_any_s)
    );

    // Next-cycle flit selection with multicast destination rewrite.
    always_comb begin
        nxt_valid_s = (nxt_state_s == ST_SEND);
        sel_flit_s  = nxt_flits_s[int'(nxt_cnt_s) * FLIT_W +: FLIT_W];
        dest_flit_s = sel_flit_s;
        dest_flit_s[DEST_LSB +: DW] = nxt_dest_s;
        nxt_out_flit_s = (nxt_mcast_s && nxt_any_s && (nxt_cnt_s == '0)) ? dest_flit_s : sel_flit_s;
        if (nxt_len_s == CNT_W'(1)) begin
            nxt_ctrl_s = CTRL_TAIL;
        end else if (nxt_cnt_s == '0) begin
            nxt_ctrl_s = CTRL_HEAD;
        end else if (nxt_cnt_s == (nxt_len_s - CNT_W'(1))) begin
            nxt_ctrl_s = CTRL_TAIL;
        end else begin
            nxt_ctrl_s = CTRL_BODY;
        end
    end

    // Uploader FSM with registered outputs; reset aborts without msg_done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            flits_r     <= '0;
            len_r       <= '0;
            cnt_r       <= '0;
            mcast_r     <= 1'b0;
            mask_r      <= '0;
            dest_r      <= '0;
            out_flit_r  <= '0;
            out_ctrl_r  <= CTRL_NONE;
            out_valid_r <= 1'b0;
            msg_ready_r <= 1'b1;
            msg_done_r  <= 1'b0;
        end else begin
            state_r     <= nxt_state_s;
            flits_r     <= nxt_flits_s;
            len_r       <= nxt_len_s;
            cnt_r       <= nxt_cnt_s;
            mcast_r     <= nxt_mcast_s;
            mask_r      <= nxt_mask_s;
            dest_r      <= nxt_dest_s;
            out_flit_r  <= nxt_valid_s ? nxt_out_flit_s : '0;
            out_ctrl_r  <= nxt_valid_s ? nxt_ctrl_s : CTRL_NONE;
            out_valid_r <= nxt_valid_s;
            msg_ready_r <= (nxt_state_s == ST_IDLE);
            msg_done_r  <= (nxt_state_s == ST_DONE);
        end
    end

    assign bus.out_flit   = out_flit_r;
    assign bus.out_ctrl   = out_ctrl_r;
    assign bus.out_valid  = out_valid_r;
    assign bus.msg_ready  = msg_ready_r;
    assign bus.msg_done   = msg_done_r;
    assign fsm_state_out  = state_r;

endmodule
